reg_serial_reader: RTL and testbench

Reader side of the 32-bit register: accepts a word presented on a register output via a valid/ready handshake. Shifts the word out MSB-first on a single serial line, each bit held for a programmable number of clock cycles. Sits between a 32-bit register and the birdhouse's serial peripheral link (display/logger). Signals frame activity, per-bit strobes and completion.

---
 rtl/reg_serial_pkg.sv | 18 +
 rtl/bit_tick_counter.sv | 29 ++
 rtl/reg_serial_reader.sv | 142 ++++++++++++++
 tb/tb_reg_serial_reader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_serial_pkg.sv
// Shared types and defaults for the register serial reader.
package reg_serial_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned DIV_DEF   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter width for a modulus/range of n, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bit_tick_counter.sv
// DIV-modulo cycle counter: flags the first and last cycle of each bit period.
module bit_tick_counter
    import reg_serial_pkg::*;
#(
    parameter int unsigned DIV = DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic first_c,
    output logic last_c
);

    localparam int unsigned CW = cnt_width(DIV);

    logic [CW-1:0] cnt;

    assign first_c = (cnt == '0);
    assign last_c  = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last_c ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/reg_serial_reader.sv
// Accepts a register word and shifts it out MSB-first, each bit held DIV cycles.
// Define PARITY_EN to append an even-parity slot after the LSB.
module reg_serial_reader
    import reg_serial_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DIV   = DIV_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_en,
    output logic             bit_strobe,
    output logic             done
);

    localparam int unsigned BW = cnt_width(WIDTH);

    state_t           state, state_d;
    logic [WIDTH-1:0] shreg, shreg_d;
    logic [BW-1:0]    bit_idx, bit_idx_d;
    logic             in_ready_d, ser_out_d, ser_en_d, bit_strobe_d, done_d;
    logic             tick_en_c, tick_first_c, tick_last_c;
`ifdef PARITY_EN
    logic             par, par_d, par_slot, par_slot_d;
`endif

    assign tick_en_c = (state == SHIFT);

    bit_tick_counter #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .en      (tick_en_c),
        .first_c (tick_first_c),
        .last_c  (tick_last_c)
    );

    // Outputs are registered as the values for the cycle following each edge.
    always_comb begin
        state_d      = state;
        shreg_d      = shreg;
        bit_idx_d    = bit_idx;
        in_ready_d   = 1'b0;
        ser_out_d    = 1'b0;
        ser_en_d     = 1'b0;
        bit_strobe_d = 1'b0;
        done_d       = 1'b0;
`ifdef PARITY_EN
        par_d        = par;
        par_slot_d   = par_slot;
`endif
        case (state)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready) begin
                    state_d      = SHIFT;
                    shreg_d      = in_data;
                    bit_idx_d    = BW'(WIDTH - 1);
                    in_ready_d   = 1'b0;
                    ser_en_d     = 1'b1;
                    ser_out_d    = in_data[WIDTH-1];
                    bit_strobe_d = 1'b1;
`ifdef PARITY_EN
                    par_d        = ^in_data;
                    par_slot_d   = 1'b0;
`endif
                end
            end
            SHIFT: begin
                ser_en_d  = 1'b1;
                ser_out_d = ser_out;
                if (tick_last_c) begin
                    if (bit_idx != '0) begin
                        // Shift so the next bit is always at the top of the register.
                        bit_idx_d    = bit_idx - BW'(1);
                        shreg_d      = shreg << 1;
                        ser_out_d    = shreg[WIDTH-2];
                        bit_strobe_d = 1'b1;
                    end
`ifdef PARITY_EN
                    else if (!par_slot) begin
                        par_slot_d   = 1'b1;
                        ser_out_d    = par;
                        bit_strobe_d = 1'b1;
                    end
`endif
                    else begin
                        state_d   = DONE;
                        ser_en_d  = 1'b0;
                        ser_out_d = 1'b0;
                        done_d    = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d    = IDLE;
                in_ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_idx    <= '0;
            in_ready   <= 1'b0;
            ser_out    <= 1'b0;
            ser_en     <= 1'b0;
            bit_strobe <= 1'b0;
            done       <= 1'b0;
`ifdef PARITY_EN
            par        <= 1'b0;
            par_slot   <= 1'b0;
`endif
        end else begin
            state      <= state_d;
            shreg      <= shreg_d;
            bit_idx    <= bit_idx_d;
            in_ready   <= in_ready_d;
            ser_out    <= ser_out_d;
            ser_en     <= ser_en_d;
            bit_strobe <= bit_strobe_d;
            done       <= done_d;
`ifdef PARITY_EN
            par        <= par_d;
            par_slot   <= par_slot_d;
`endif
        end
    end

    // The strobe register must line up with the tick counter's first cycle.
    strobe_aligned: assert property (@(posedge clk) disable iff (!reset)
        (state == SHIFT) |-> (bit_strobe == tick_first_c));

endmodule

// File: tb/tb_reg_serial_reader.sv
// Randomized self-checking bench for reg_serial_reader (DIV=2 and DIV=1 instances).
module tb_reg_serial_reader;

    localparam int unsigned W = 32;
`ifdef PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic         clk    = 1'b0;
    logic         reset  = 1'b0;
    logic [W-1:0] data2  = '0;
    logic [W-1:0] data1  = '0;
    logic         valid2 = 1'b0;
    logic         valid1 = 1'b0;
    logic         rdy2, so2, en2, stb2, dn2;
    logic         rdy1, so1, en1, stb1, dn1;
    logic         sel    = 1'b0;
    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    reg_serial_reader #(.WIDTH(W), .DIV(2)) u_d2 (
        .clk(clk), .reset(reset), .in_data(data2), .in_valid(valid2), .in_ready(rdy2),
        .ser_out(so2), .ser_en(en2), .bit_strobe(stb2), .done(dn2)
    );

    reg_serial_reader #(.WIDTH(W), .DIV(1)) u_d1 (
        .clk(clk), .reset(reset), .in_data(data1), .in_valid(valid1), .in_ready(rdy1),
        .ser_out(so1), .ser_en(en1), .bit_strobe(stb1), .done(dn1)
    );

    // {in_ready, ser_en, ser_out, bit_strobe, done} of the selected instance
    function automatic logic [4:0] obs();
        return sel ? {rdy1, en1, so1, stb1, dn1} : {rdy2, en2, so2, stb2, dn2};
    endfunction

    // Reference: outputs j cycles after the accepting edge, from slot arithmetic.
    function automatic logic [4:0] model(input logic [W-1:0] w, input int j, input int d);
        int   slots;
        int   total;
        int   s;
        logic b;
        slots = int'(W) + PAR;
        total = slots * d;
        if (j < total) begin
            s = j / d;
            b = (s < int'(W)) ? w[int'(W) - 1 - s] : ^w;
            return {1'b0, 1'b1, b, (j % d == 0), 1'b0};
        end else if (j == total) begin
            return 5'b00001;
        end
        return 5'b10000;
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] dat);
        if (sel) begin
            valid1 = v;
            data1  = dat;
        end else begin
            valid2 = v;
            data2  = dat;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if ({rdy2, en2, so2, stb2, dn2, rdy1, en1, so1, stb1, dn1} !== 10'b0) begin
                errors++;
                $display("FAIL reset_hold got=%b exp=%b",
                         {rdy2, en2, so2, stb2, dn2, rdy1, en1, so1, stb1, dn1}, 10'b0);
            end
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({rdy2, rdy1} !== 2'b00) begin
            errors++;
            $display("FAIL ready_before_edge got=%b exp=00", {rdy2, rdy1});
        end
        @(posedge clk); #1;
        checks++;
        if ({rdy2, en2, so2, stb2, dn2, rdy1, en1, so1, stb1, dn1} !== 10'b1000010000) begin
            errors++;
            $display("FAIL reset_release got=%b exp=%b",
                     {rdy2, en2, so2, stb2, dn2, rdy1, en1, so1, stb1, dn1}, 10'b1000010000);
        end
    endtask

    task automatic wait_ready(input string name);
        int          n;
        logic [4:0]  got;
        n   = 0;
        got = obs();
        while (got[4] !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            got = obs();
            n++;
        end
        checks++;
        if (got[4] !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_timeout got=%b exp=1", name, got[4]);
        end
    endtask

    task automatic test_frame(input logic use1, input logic [W-1:0] w, input string name);
        int         d;
        logic [4:0] got, exp;
        sel = use1;
        d   = use1 ? 1 : 2;
        wait_ready(name);
        drive(1'b1, w);
        @(posedge clk); #1;
        drive(1'b0, W'($urandom));
        for (int j = 0; j <= (int'(W) + PAR) * d + 1; j++) begin
            got = obs();
            exp = model(w, j, d);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s j=%0d got=%b exp=%b", name, j, got, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int           p;
        logic [W-1:0] w0, w1, cur;
        logic [4:0]   got, exp;
        sel = 1'b0;
        p   = (int'(W) + PAR) * 2 + 2;
        wait_ready("b2b");
        w0 = W'($urandom);
        w1 = '0;
        drive(1'b1, w0);
        @(posedge clk); #1;
        for (int e = 0; e < 2 * p; e++) begin
            got = obs();
            exp = (e < p) ? model(w0, e, 2) : model(w1, e - p, 2);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL b2b e=%0d got=%b exp=%b", e, got, exp);
            end
            cur = W'($urandom);
            if (e + 1 == p) w1 = cur;
            drive((e + 1 < 2 * p) ? 1'b1 : 1'b0, cur);
            @(posedge clk); #1;
        end
        got = obs();
        checks++;
        if (got !== 5'b10000) begin
            errors++;
            $display("FAIL b2b_no_third got=%b exp=%b", got, 5'b10000);
        end
    endtask

    task automatic test_reset_midframe();
        logic [W-1:0] w;
        logic [4:0]   got, exp;
        sel = 1'b0;
        wait_ready("mid");
        w = W'($urandom);
        drive(1'b1, w);
        @(posedge clk); #1;
        drive(1'b0, W'($urandom));
        for (int j = 0; j < 21; j++) begin
            got = obs();
            exp = model(w, j, 2);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL mid_pre j=%0d got=%b exp=%b", j, got, exp);
            end
            @(posedge clk); #1;
        end
        #2;
        reset = 1'b0;
        #1;
        got = obs();
        checks++;
        if (got !== 5'b00000) begin
            errors++;
            $display("FAIL mid_async_abort got=%b exp=%b", got, 5'b00000);
        end
        repeat (2) begin
            @(posedge clk); #1;
            got = obs();
            checks++;
            if (got !== 5'b00000) begin
                errors++;
                $display("FAIL mid_hold got=%b exp=%b", got, 5'b00000);
            end
        end
        reset = 1'b1;
        @(posedge clk); #1;
        got = obs();
        checks++;
        if (got !== 5'b10000) begin
            errors++;
            $display("FAIL mid_release got=%b exp=%b", got, 5'b10000);
        end
        test_frame(1'b0, 32'h0000_0003, "after_reset");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_frame(1'b0, 32'hA500_0001, "a5_div2");
        test_frame(1'b1, 32'hFFFF_FFFF, "ones_div1");
        for (int i = 0; i < 3; i++) begin
            test_frame(1'b0, W'($urandom), "rand_div2");
            test_frame(1'b1, W'($urandom), "rand_div1");
        end
        test_frame(1'b0, 32'h0000_0007, "w7_div2");
        test_frame(1'b0, 32'h0000_0003, "w3_div2");
        test_back_to_back();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
